layer_1_sequencer: RTL and testbench

// - Sequences the 5-lane layer-1 multiply/accumulate datapath across all 20 hidden neurons for one 256-pixel binary image.
// - Runs 4 groups of 5 neurons. Per group it issues 256 weight reads and drives accumulate plus the per-pixel mask bit.
// - Per group it then waits for datapath completion and hands the 5 sums to the result consumer with a valid/ready handshake.
// - Sits between the image/weight memories and layer_1_5_multiply; replaces bench-driven load/accumulate/shift sequencing.

---
 rtl/layer_1_sequencer.sv | 138 +++++++++++++
 tb/tb_layer_1_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_1_sequencer.sv
// rtl/layer_1_sequencer.sv - group/pixel sequencer for the 5-lane layer-1 MAC datapath
// Optional LAYER1_SEQ_SKIP_ZERO_EN: suppress weight reads and accumulates for zero pixels.
module layer_1_sequencer #(
  parameter int N_INPUTS  = 256,
  parameter int N_NEURONS = 20,
  parameter int LANES     = 5,
  localparam int GROUPS   = N_NEURONS / LANES,
  localparam int PIX_W    = $clog2(N_INPUTS),
  localparam int GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [N_INPUTS-1:0] i_image_bits,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_weight_rd_en,
  output logic [GRP_W-1:0]    o_weight_group,
  output logic [PIX_W-1:0]    o_weight_pixel,
  output logic                o_mac_accumulate,
  output logic                o_mac_mask,
  output logic                o_mac_load,
  output logic                o_mac_clear,
  input  logic                i_mac_done,
  output logic                o_result_valid,
  output logic [GRP_W-1:0]    o_result_group,
  input  logic                i_result_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [PIX_W:0]   CNT_END   = (PIX_W + 1)'(N_INPUTS);
  localparam logic [GRP_W-1:0] GRP_LAST  = GRP_W'(GROUPS - 1);

  logic [2:0]          r_state;
  logic [PIX_W:0]      r_cnt;
  logic [GRP_W-1:0]    r_group;
  logic [N_INPUTS-1:0] r_image;
  logic                r_acc;
  logic                r_mask;
  logic                r_abort_clr;

  logic w_in_range;
  logic w_pix_bit;
  logic w_rd_en;

  // The image register rotates one pixel per read so the current pixel is
  // always the MSB; after N_INPUTS rotations it is back in place for the next group.
  assign w_pix_bit  = r_image[N_INPUTS-1];
  assign w_in_range = (r_state == S_RUN) && (r_cnt < CNT_END);

`ifdef LAYER1_SEQ_SKIP_ZERO_EN
  assign w_rd_en = w_in_range && w_pix_bit;
`else
  assign w_rd_en = w_in_range;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_group     <= '0;
      r_image     <= '0;
      r_acc       <= 1'b0;
      r_mask      <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_abort_clr <= 1'b0;
      r_acc       <= 1'b0;
      r_mask      <= 1'b0;
      if (i_abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_group     <= '0;
        r_abort_clr <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_image <= i_image_bits;
              r_group <= '0;
              r_state <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
          S_RUN: begin
            r_acc  <= w_rd_en;
            r_mask <= w_in_range && w_pix_bit;
            if (w_in_range) begin
              r_image <= {r_image[N_INPUTS-2:0], r_image[N_INPUTS-1]};
              r_cnt   <= r_cnt + 1'b1;
            end else begin
              r_state <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            if (i_mac_done) r_state <= S_OUTPUT;
          end
          S_OUTPUT: begin
            if (i_result_ready) begin
              if (r_group == GRP_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_group <= r_group + 1'b1;
                r_state <= S_CLEAR;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy           = (r_state == S_CLEAR) || (r_state == S_RUN) ||
                            (r_state == S_FLUSH) || (r_state == S_OUTPUT);
  assign o_done           = (r_state == S_DONE);
  assign o_weight_rd_en   = w_rd_en;
  assign o_weight_group   = r_group;
  assign o_weight_pixel   = (r_state == S_RUN) ? r_cnt[PIX_W-1:0] : '0;
  assign o_mac_accumulate = r_acc;
  assign o_mac_mask       = r_mask;
  assign o_mac_load       = (r_state == S_RUN);
  assign o_mac_clear      = (r_state == S_CLEAR) || r_abort_clr;
  assign o_result_valid   = (r_state == S_OUTPUT);
  assign o_result_group   = r_group;

endmodule

// File: tb/tb_layer_1_sequencer.sv
// tb/tb_layer_1_sequencer.sv - directed bench for layer_1_sequencer
// Honours LAYER1_SEQ_SKIP_ZERO_EN when compiled with it.
module tb_layer_1_sequencer;

`ifdef LAYER1_SEQ_SKIP_ZERO_EN
  localparam bit SKIP  = 1'b1;
  localparam int RD_AA = 128;
`else
  localparam bit SKIP  = 1'b0;
  localparam int RD_AA = 256;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, abort, mac_done, rready;
  logic [255:0] image_bits;
  logic         busy, done, rd_en, acc, mask, load, clr, rvalid;
  logic [1:0]   wgrp, rgrp;
  logic [7:0]   wpix;

  always #5 clk = ~clk;

  layer_1_sequencer dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
    .i_image_bits(image_bits), .o_busy(busy), .o_done(done),
    .o_weight_rd_en(rd_en), .o_weight_group(wgrp), .o_weight_pixel(wpix),
    .o_mac_accumulate(acc), .o_mac_mask(mask), .o_mac_load(load),
    .o_mac_clear(clr), .i_mac_done(mac_done), .o_result_valid(rvalid),
    .o_result_group(rgrp), .i_result_ready(rready)
  );

  int total = 0;
  int bad   = 0;

  int         rd_cnt [4];
  int         vcyc   [4];
  logic [1:0] hs_grp [8];
  int         hs_cnt, done_cnt, busy_cyc, ord_err, trail_err, clr_err;
  int         stall_grp, stall_left, fl_cnt;
  bit         trail_en, expect_clr, prev_rd;
  logic [7:0] prev_pix, exp_pix;
  logic [255:0] cur_img;

  // Datapath, memory and consumer model: drives mac_done / ready and tallies activity.
  always @(negedge clk) begin
    if (expect_clr) begin
      if (!clr) clr_err++;
      expect_clr = 1'b0;
    end
    if (rvalid && stall_left > 0 && int'(rgrp) == stall_grp) begin
      rready = 1'b0;
      stall_left--;
    end else begin
      rready = 1'b1;
    end
    if (rvalid) begin
      vcyc[rgrp]++;
      if (rready) begin
        if (hs_cnt < 8) hs_grp[hs_cnt] = rgrp;
        hs_cnt++;
        expect_clr = (rgrp != 2'd3);
      end
    end
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (rd_en) begin
      rd_cnt[wgrp]++;
      if (SKIP) begin
        if (cur_img[255 - wpix] !== 1'b1) ord_err++;
      end else begin
        if (wpix !== exp_pix) ord_err++;
        exp_pix = wpix + 8'd1;
      end
    end
    if (trail_en) begin
      if (acc !== prev_rd) trail_err++;
      if (mask !== (prev_rd ? cur_img[255 - prev_pix] : 1'b0)) trail_err++;
    end
    prev_rd  = rd_en;
    prev_pix = wpix;
    if (busy && !load && !clr && !rvalid) fl_cnt++;
    else fl_cnt = 0;
    mac_done = (fl_cnt >= 2);
  end

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin rd_cnt[i] = 0; vcyc[i] = 0; end
    for (int i = 0; i < 8; i++) hs_grp[i] = 2'd0;
    hs_cnt = 0; done_cnt = 0; busy_cyc = 0; ord_err = 0; trail_err = 0;
    clr_err = 0; exp_pix = 8'd0; stall_grp = -1; stall_left = 0;
  endtask

  task automatic start_frame(input logic [255:0] img);
    @(negedge clk);
    cur_img    = img;
    image_bits = img;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; image_bits = '1; cur_img = '1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, rd_en, acc, mask, load, clr, rvalid, wgrp, wpix, rgrp} !== 20'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {busy, done, rd_en, acc, mask, load, clr, rvalid, wgrp, wpix, rgrp});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, clr, load} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b want=000", {busy, clr, load}); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, clr, load} !== 3'b110) begin bad++; $display("FAIL start_clear got=%b want=110", {busy, clr, load}); end
    @(negedge clk);
    total++;
    if ({clr, load, rd_en, wpix} !== {3'b011, 8'd0}) begin
      bad++; $display("FAIL first_run got=%h want=%h", {clr, load, rd_en, wpix}, {3'b011, 8'd0});
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, load, rd_en, acc, wpix} !== 12'd0) begin
      bad++; $display("FAIL async_reset got=%h want=0", {busy, load, rd_en, acc, wpix});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL no_restart got=%b want=0", busy); end
  endtask

  task automatic test_full_frame();
    bit to;
    clear_stats();
    start_frame('1);
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL full_timeout got=1 want=0"); end
    for (int g = 0; g < 4; g++) begin
      total++;
      if (rd_cnt[g] != 256) begin bad++; $display("FAIL full_rd_cnt g%0d got=%0d want=256", g, rd_cnt[g]); end
    end
    for (int g = 0; g < 4; g++) begin
      total++;
      if (hs_grp[g] !== 2'(g)) begin bad++; $display("FAIL full_hs_order %0d got=%0d want=%0d", g, hs_grp[g], g); end
    end
    total++; if (hs_cnt != 4) begin bad++; $display("FAIL full_hs_cnt got=%0d want=4", hs_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done got=%0d want=1", done_cnt); end
    total++; if (busy_cyc != 1044) begin bad++; $display("FAIL full_busy_cyc got=%0d want=1044", busy_cyc); end
    total++; if (ord_err != 0) begin bad++; $display("FAIL full_pixel_order got=%0d want=0", ord_err); end
    total++; if (trail_err != 0) begin bad++; $display("FAIL full_trail got=%0d want=0", trail_err); end
    total++; if (clr_err != 0) begin bad++; $display("FAIL full_clear_after_hs got=%0d want=0", clr_err); end
  endtask

  task automatic test_mask_pattern();
    bit to;
    bit hit;
    logic [255:0] img;
    logic [3:0] exp_mask;
    logic [3:0] exp_acc;
    img      = {64{4'hA}};
    exp_mask = 4'b1010;
    exp_acc  = SKIP ? 4'b1010 : 4'b1111;
    clear_stats();
    start_frame(img);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!hit) begin bad++; $display("FAIL aa_acc_start got=0 want=1"); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({acc, mask} !== {exp_acc[3-k], exp_mask[3-k]}) begin
        bad++; $display("FAIL aa_pixel%0d got=%b want=%b", k, {acc, mask}, {exp_acc[3-k], exp_mask[3-k]});
      end
      @(negedge clk);
    end
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL aa_timeout got=1 want=0"); end
    for (int g = 0; g < 4; g++) begin
      total++;
      if (rd_cnt[g] != RD_AA) begin bad++; $display("FAIL aa_rd_cnt g%0d got=%0d want=%0d", g, rd_cnt[g], RD_AA); end
    end
    total++; if (busy_cyc != 1044) begin bad++; $display("FAIL aa_busy_cyc got=%0d want=1044", busy_cyc); end
    total++; if (trail_err != 0) begin bad++; $display("FAIL aa_trail got=%0d want=0", trail_err); end
    total++; if (ord_err != 0) begin bad++; $display("FAIL aa_pixel_order got=%0d want=0", ord_err); end
  endtask

  task automatic test_ready_stall();
    bit to;
    clear_stats();
    stall_grp  = 1;
    stall_left = 10;
    start_frame('1);
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL stall_timeout got=1 want=0"); end
    total++; if (vcyc[1] != 11) begin bad++; $display("FAIL stall_valid_g1 got=%0d want=11", vcyc[1]); end
    total++;
    if (vcyc[0] + vcyc[2] + vcyc[3] != 3) begin
      bad++; $display("FAIL stall_valid_other got=%0d want=3", vcyc[0] + vcyc[2] + vcyc[3]);
    end
    total++; if (hs_cnt != 4) begin bad++; $display("FAIL stall_hs_cnt got=%0d want=4", hs_cnt); end
    total++; if (hs_grp[1] !== 2'd1) begin bad++; $display("FAIL stall_hs_g1 got=%0d want=1", hs_grp[1]); end
    total++; if (busy_cyc != 1054) begin bad++; $display("FAIL stall_busy_cyc got=%0d want=1054", busy_cyc); end
    total++; if (clr_err != 0) begin bad++; $display("FAIL stall_clear_resume got=%0d want=0", clr_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_abort();
    bit to;
    bit hit;
    clear_stats();
    trail_en = 1'b0;
    start_frame('1);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rd_en && wgrp == 2'd2 && wpix == 8'd100) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach_g2p100 got=0 want=1"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy, rvalid, clr, load, rd_en, acc} !== 6'b001000) begin
      bad++; $display("FAIL abort_idle got=%b want=001000", {busy, rvalid, clr, load, rd_en, acc});
    end
    @(negedge clk);
    total++; if (clr !== 1'b0) begin bad++; $display("FAIL abort_clear_pulse got=%b want=0", clr); end
    repeat (5) @(negedge clk);
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_stays_idle got=%b want=0", busy); end
    trail_en = 1'b1;
    clear_stats();
    start_frame('1);
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL restart_timeout got=1 want=0"); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
    total++; if (hs_cnt != 4) begin bad++; $display("FAIL restart_hs_cnt got=%0d want=4", hs_cnt); end
    total++; if (rd_cnt[2] != 256) begin bad++; $display("FAIL restart_rd_g2 got=%0d want=256", rd_cnt[2]); end
    total++; if (busy_cyc != 1044) begin bad++; $display("FAIL restart_busy_cyc got=%0d want=1044", busy_cyc); end
  endtask

  initial begin
    mac_done = 1'b0; rready = 1'b1; trail_en = 1'b1; expect_clr = 1'b0;
    prev_rd = 1'b0; prev_pix = 8'd0; fl_cnt = 0;
    clear_stats();
    test_reset();
    test_full_frame();
    test_mask_pattern();
    test_ready_stall();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
